// File: rtl/monexp_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : monexp_ctrl_if                                                |
// | Purpose  : Bundles the host request/result signals and the shared monmul |
// |            operand/handshake signals of the modular-exponentiation       |
// |            sequencer.                                                    |
// | Signals  : x, e, start        host -> sequencer (base, exponent, request)|
// |            z, done, busy      sequencer -> host (result, pulse, status)  |
// |            mm_x, mm_y         sequencer -> monmul operands A and B       |
// |            mm_start           sequencer -> monmul one-cycle start        |
// |            mm_z, mm_done      monmul -> sequencer product and done level |
// | Modports : slave  - the sequencer itself                                 |
// |            master - the environment (host plus monmul)                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface monexp_ctrl_if #(
  parameter int K  = 8,
  parameter int EW = 8
);
  logic [K-1:0]  x;
  logic [EW-1:0] e;
  logic          start;
  logic [K-1:0]  z;
  logic          done;
  logic          busy;
  logic [K-1:0]  mm_x;
  logic [K-1:0]  mm_y;
  logic          mm_start;
  logic [K-1:0]  mm_z;
  logic          mm_done;

  modport slave (
    input  x, e, start, mm_z, mm_done,
    output z, done, busy, mm_x, mm_y, mm_start
  );

  modport master (
    output x, e, start, mm_z, mm_done,
    input  z, done, busy, mm_x, mm_y, mm_start
  );
endinterface
`default_nettype wire

// File: rtl/monexp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : monexp_ctrl                                                   |
// | Purpose  : Computes z = x^e mod M by scheduling Montgomery products on   |
// |            one external monmul. Left-to-right square-and-multiply in the |
// |            Montgomery domain with exactly EW squarings per run.          |
// | Ports    : clk_i     rising-edge clock                                   |
// |            reset_ni  asynchronous active-low reset                       |
// |            ctrl_if   host request/result and monmul handshake bundle     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module monexp_ctrl #(
  parameter int           K  = 8,
  parameter logic [K-1:0] M  = 8'd239,
  parameter int           EW = 8,
  parameter logic [K-1:0] R1 = 8'd17,
  parameter logic [K-1:0] R2 = 8'd50
) (
  input  wire logic       clk_i,
  input  wire logic       reset_ni,
  monexp_ctrl_if.slave    ctrl_if
);

  localparam int CW = (EW > 1) ? $clog2(EW) : 1;

  // The constants are only meaningful for an odd modulus with R1, R2 reduced.
  if ((M % 2) == 0 || R1 >= M || R2 >= M) begin : g_param_check
    $error("monexp_ctrl: M must be odd and R1, R2 must be below M");
  end

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    TOM_I = 4'd1,
    TOM_W = 4'd2,
    SQR_I = 4'd3,
    SQR_W = 4'd4,
    MUL_I = 4'd5,
    MUL_W = 4'd6,
    NEXT  = 4'd7,
    FRM_I = 4'd8,
    FRM_W = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] e_q, e_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [K-1:0]  acc_q, acc_d;
  logic [K-1:0]  xm_q, xm_d;
  logic [K-1:0]  z_q, z_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [K-1:0]  mm_x_q, mm_x_d;
  logic [K-1:0]  mm_y_q, mm_y_d;
  logic          mm_start_q, mm_start_d;
  logic          mm_done_q;
  logic          ev;

  // Only a rising edge of mm_done marks a fresh product.
  assign ev = ctrl_if.mm_done & ~mm_done_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      e_q        <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      xm_q       <= '0;
      z_q        <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_x_q     <= '0;
      mm_y_q     <= '0;
      mm_start_q <= 1'b0;
      mm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      xm_q       <= xm_d;
      z_q        <= z_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mm_x_q     <= mm_x_d;
      mm_y_q     <= mm_y_d;
      mm_start_q <= mm_start_d;
      mm_done_q  <= ctrl_if.mm_done;
    end
  end

  // Each ISSUE state loads the operand registers and raises mm_start for one
  // cycle; the operands are held untouched through the matching WAIT state.
  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    xm_d       = xm_q;
    z_d        = z_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    mm_x_d     = mm_x_q;
    mm_y_d     = mm_y_q;
    mm_start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // done_q high means the previous run finishes this cycle; a start
        // seen now is dropped and only honoured one cycle later.
        if (ctrl_if.start && !done_q) begin
          // xm holds the plain base until the conversion product replaces it.
          xm_d    = ctrl_if.x;
          e_d     = ctrl_if.e;
          acc_d   = R1;
          cnt_d   = CW'(EW - 1);
          busy_d  = 1'b1;
          state_d = TOM_I;
        end
      end
      TOM_I: begin
        mm_x_d     = xm_q;
        mm_y_d     = R2;
        mm_start_d = 1'b1;
        state_d    = TOM_W;
      end
      TOM_W: begin
        if (ev) begin
          xm_d    = ctrl_if.mm_z;
          state_d = SQR_I;
        end
      end
      SQR_I: begin
        mm_x_d     = acc_q;
        mm_y_d     = acc_q;
        mm_start_d = 1'b1;
        state_d    = SQR_W;
      end
      SQR_W: begin
        if (ev) begin
          acc_d   = ctrl_if.mm_z;
          state_d = e_q[cnt_q] ? MUL_I : NEXT;
        end
      end
      MUL_I: begin
        mm_x_d     = acc_q;
        mm_y_d     = xm_q;
        mm_start_d = 1'b1;
        state_d    = MUL_W;
      end
      MUL_W: begin
        if (ev) begin
          acc_d   = ctrl_if.mm_z;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (cnt_q == '0) begin
          state_d = FRM_I;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = SQR_I;
        end
      end
      FRM_I: begin
        // Multiplying by plain 1 strips the Montgomery factor R.
        mm_x_d     = acc_q;
        mm_y_d     = K'(1);
        mm_start_d = 1'b1;
        state_d    = FRM_W;
      end
      FRM_W: begin
        if (ev) begin
          z_d     = ctrl_if.mm_z;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ctrl_if.z        = z_q;
  assign ctrl_if.done     = done_q;
  assign ctrl_if.busy     = busy_q;
  assign ctrl_if.mm_x     = mm_x_q;
  assign ctrl_if.mm_y     = mm_y_q;
  assign ctrl_if.mm_start = mm_start_q;

endmodule
`default_nettype wire

// File: tb/tb_monexp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_monexp_ctrl                                                |
// | Purpose  : Self-checking bench for monexp_ctrl with a behavioural monmul |
// |            (random latency) and a plain pow-mod reference.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_monexp_ctrl;
  localparam int K   = 8;
  localparam int EW  = 8;
  localparam int MOD = 239;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #50 clk = ~clk;

  monexp_ctrl_if #(.K(K), .EW(EW)) bus ();

  monexp_ctrl #(
    .K (K),
    .M (8'd239),
    .EW(EW),
    .R1(8'd17),
    .R2(8'd50)
  ) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .ctrl_if (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural monmul ----------------
  int         n_start   = 0;
  int         proto_err = 0;
  int         stab_err  = 0;
  logic       stray_req = 1'b0;
  logic       mm_busy;
  int         mm_cnt;
  logic [7:0] sa, sb;

  function automatic int mont(input int a, input int b);
    int rinv = 0;
    for (int r = 1; r < MOD; r++) if (((256 * r) % MOD) == 1) rinv = r;
    return ((a * b) % MOD) * rinv % MOD;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mm_done <= 1'b0;
      bus.mm_z    <= '0;
      mm_busy     <= 1'b0;
      mm_cnt      <= 0;
      sa          <= '0;
      sb          <= '0;
    end else if (bus.mm_start) begin
      if (mm_busy) proto_err <= proto_err + 1;
      n_start     <= n_start + 1;
      sa          <= bus.mm_x;
      sb          <= bus.mm_y;
      mm_busy     <= 1'b1;
      mm_cnt      <= int'($urandom_range(1, 4));
      bus.mm_done <= 1'b0;
    end else if (mm_busy) begin
      if (bus.mm_x !== sa || bus.mm_y !== sb) stab_err <= stab_err + 1;
      if (mm_cnt == 0) begin
        bus.mm_done <= 1'b1;
        bus.mm_z    <= 8'(mont(int'(sa), int'(sb)));
        mm_busy     <= 1'b0;
      end else begin
        mm_cnt <= mm_cnt - 1;
      end
    end else if (stray_req) begin
      bus.mm_done <= ~bus.mm_done;
      bus.mm_z    <= 8'h5A;
    end
  end

  // ---------------- reference and helpers ----------------
  function automatic int powmod(input int x, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * x) % MOD;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name, output int ndone);
    bit seen = 1'b0;
    ndone = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    if (seen) ndone = 1;
    check({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic run(input logic [7:0] x, input logic [7:0] e,
                     output logic [7:0] z, output int ops);
    int s0, nd;
    @(negedge clk);
    bus.x = x; bus.e = e; bus.start = 1'b1;
    s0 = n_start;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("run", nd);
    z   = bus.z;
    ops = n_start - s0;
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] e;
    logic [7:0] z;
    int         ops;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] z;
  int         ops, nd, s0;
  logic [7:0] rx, re;

  initial begin
    tbl[0] = '{x: 8'd2,   e: 8'd10,  z: 8'd68,  ops: 12};
    tbl[1] = '{x: 8'd202, e: 8'd1,   z: 8'd202, ops: 11};
    tbl[2] = '{x: 8'd3,   e: 8'd238, z: 8'd1,   ops: 16};
    tbl[3] = '{x: 8'd5,   e: 8'd0,   z: 8'd1,   ops: 10};
    tbl[4] = '{x: 8'd0,   e: 8'd0,   z: 8'd1,   ops: 10};
    tbl[5] = '{x: 8'd0,   e: 8'd7,   z: 8'd0,   ops: 13};

    bus.x = '0; bus.e = '0; bus.start = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_z",        int'(bus.z),        0);
    check("rst_done",     int'(bus.done),     0);
    check("rst_busy",     int'(bus.busy),     0);
    check("rst_mm_x",     int'(bus.mm_x),     0);
    check("rst_mm_y",     int'(bus.mm_y),     0);
    check("rst_mm_start", int'(bus.mm_start), 0);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run(tbl[i].x, tbl[i].e, z, ops);
      check($sformatf("vec%0d_z", i),   int'(z), int'(tbl[i].z));
      check($sformatf("vec%0d_ops", i), ops,     tbl[i].ops);
    end

    // Stray mm_done edge while idle must not disturb anything
    @(negedge clk);
    stray_req = 1'b1;
    repeat (2) @(negedge clk);
    stray_req = 1'b0;
    count_done(4, nd);
    check("stray_done", nd,            0);
    check("stray_busy", int'(bus.busy), 0);
    check("stray_z",    int'(bus.z),    0);

    // Start held only during the done cycle is ignored
    run(8'd4, 8'd3, z, ops);
    check("dc_z", int'(z), 64);
    bus.start = 1'b1; bus.x = 8'd9; bus.e = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("dc_start_ignored", int'(bus.busy), 0);
    check("dc_z_held",        int'(bus.z),    64);

    // Back-to-back runs, each start the cycle after done
    for (int x = 203; x <= 205; x++) begin
      run(8'(x), 8'd255, z, ops);
      check($sformatf("b2b%0d_z", x),   int'(z), powmod(x, 255));
      check($sformatf("b2b%0d_ops", x), ops,     18);
    end

    // Start pulses and input changes mid-run have no effect
    @(negedge clk);
    bus.x = 8'd11; bus.e = 8'hB7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("mid_busy", int'(bus.busy), 1);
    repeat (20) @(negedge clk);
    bus.start = 1'b1; bus.x = 8'd100; bus.e = 8'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.x = 8'd55; bus.e = 8'd0;
    wait_done("mid", nd);
    check("mid_z", int'(bus.z), powmod(11, 183));
    count_done(60, ops);
    check("mid_one_done", nd + ops, 1);
    check("mid_idle",     int'(bus.busy), 0);

    // Reset in the first SQR wait aborts the run
    @(negedge clk);
    bus.x = 8'd7; bus.e = 8'd200; bus.start = 1'b1;
    s0 = n_start;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 200 && (n_start - s0) < 2; c++) @(negedge clk);
    check("rstmid_reached_sqr", n_start - s0, 2);
    rst_n = 1'b0;
    #1;
    check("rstmid_z",        int'(bus.z),        0);
    check("rstmid_done",     int'(bus.done),     0);
    check("rstmid_busy",     int'(bus.busy),     0);
    check("rstmid_mm_x",     int'(bus.mm_x),     0);
    check("rstmid_mm_y",     int'(bus.mm_y),     0);
    check("rstmid_mm_start", int'(bus.mm_start), 0);
    count_done(3, nd);
    rst_n = 1'b1;
    count_done(3, ops);
    check("rstmid_no_done", nd + ops, 0);
    run(8'd9, 8'd13, z, ops);
    check("rstmid_after_z", int'(z), powmod(9, 13));

    // Randomized runs against the pow-mod reference
    for (int i = 0; i < 20; i++) begin
      rx = 8'($urandom_range(0, MOD - 1));
      re = 8'($urandom_range(0, 255));
      run(rx, re, z, ops);
      check($sformatf("rnd%0d_z(x=%0d,e=%0d)", i, rx, re), int'(z), powmod(int'(rx), int'(re)));
      check($sformatf("rnd%0d_ops", i), ops, EW + 2 + $countones(re));
    end

    check("monmul_restart_while_busy", proto_err, 0);
    check("monmul_operand_stability",  stab_err,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
